conv_frame_seq: RTL

Frame sequencer for the streaming 3x3 convolution datapath (MAC/register/row-shift pipeline). It accepts one frame of M x N pixels from an upstream source over a valid/ready handshake and drives pixels into the datapath. It gates the datapath clock-enable so stalls are safe, and clears the datapath between frames. It tracks row and column, and qualifies the datapath's pxl_out as a valid output only for fully-covered (interior) windows. Sits between the pixel source (frame buffer / camera FIFO) and the conv datapath plus downstream sink.

---
 rtl/conv_frame_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/conv_frame_seq.sv
// Frame sequencer for the streaming 3x3 convolution datapath: handshake, clear, enable and output qualification.
// Optional frame-end checking (src_last / seq_err) is compiled in with `define CONV_SEQ_LAST_CHECK_EN.
module conv_frame_seq #(
  parameter int N  = 5,
  parameter int M  = 5,
  parameter int K  = 3,
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    src_pxl,
  input  logic          src_valid,
  output logic          src_ready,
  output logic [7:0]    dp_pxl,
  output logic          dp_en,
  output logic          dp_clr,
  input  logic [15:0]   dp_pxl_out,
  output logic [15:0]   out_pxl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          frame_done,
  output logic [CW-1:0] out_count
`ifdef CONV_SEQ_LAST_CHECK_EN
  ,
  input  logic          src_last,
  output logic          seq_err
`endif
);

  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int CLW = (N > 1) ? $clog2(N) : 1;

  localparam logic [RW-1:0]  ROW_LAST = RW'(M - 1);
  localparam logic [RW-1:0]  ROW_WIN  = RW'(K - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(N - 1);
  localparam logic [CLW-1:0] COL_WIN  = CLW'(K - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]     state;
  logic [RW-1:0]  row;
  logic [CLW-1:0] col;
  logic           acc, win, last, hs;

  // A pending result blocks new pixels so the datapath register holds out_pxl.
  assign src_ready  = (state == STREAM) && (!out_valid || out_ready);
  assign acc        = src_ready && src_valid;
  assign dp_en      = acc;
  assign dp_pxl     = src_pxl;
  assign dp_clr     = reset || (state == CLEAR);
  assign out_pxl    = dp_pxl_out;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign hs         = out_valid && out_ready;
  assign win        = (row >= ROW_WIN) && (col >= COL_WIN);
  assign last       = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE:    if (start) state <= CLEAR;
        CLEAR:   state <= STREAM;
        STREAM:  if (acc && last) state <= DRAIN;
        DRAIN:   if (!out_valid || out_ready) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (state == CLEAR) begin
        row <= '0;
        col <= '0;
      end else if (acc) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CLW'(1);
        end
      end

      if (acc && win)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;

      if (state == CLEAR)
        out_count <= '0;
      else if (hs)
        out_count <= out_count + CW'(1);
    end
  end

`ifdef CONV_SEQ_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset || state == CLEAR)
      seq_err <= 1'b0;
    else if (acc && (src_last != last))
      seq_err <= 1'b1;
  end
`endif

endmodule
